// File: rtl/mem_clear_seq_if.sv
// Write port between the clear sequencer and a downstream RAM controller.
interface mem_clear_seq_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  modport master (output wr_req, wr_addr, wr_data, input wr_ack);
  modport slave  (input wr_req, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/mem_clear_seq.sv
// Clear sequencer: one write per address 0..2^ADDR_W-1, GAP idle cycles after each accepted write.
// Define MEM_CLEAR_PATTERN_EN to write (address ^ FILL) instead of the constant FILL word.
module mem_clear_seq #(
  parameter int                 ADDR_W = 25,
  parameter int                 DATA_W = 16,
  parameter int                 GAP    = 8,
  parameter logic [DATA_W-1:0]  FILL   = '0
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  mem_clear_seq_if.master       wr,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            pass_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        gap_q;
  logic [7:0]        pass_q;
  logic              req_q;
  logic              busy_q;
  logic              done_q;
  logic              at_last;

  assign addr_d  = addr_q + ADDR_W'(1);
  assign at_last = (addr_q == {ADDR_W{1'b1}});

`ifdef MEM_CLEAR_PATTERN_EN
  logic [DATA_W-1:0] data_q;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'(a) ^ FILL;
  endfunction

  assign wr.wr_data = data_q;
`else
  assign wr.wr_data = FILL;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      gap_q   <= '0;
      pass_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_CLEAR_PATTERN_EN
      data_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_REQ;
            addr_q  <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef MEM_CLEAR_PATTERN_EN
            data_q  <= pattern('0);
`endif
          end
        end
        S_REQ: begin
          // Request is held regardless of pause until the controller accepts it.
          if (wr.wr_ack) begin
            if (at_last) begin
              state_q <= S_DONE;
              req_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (pass_q != 8'hFF) pass_q <= pass_q + 8'd1;
            end else begin
              addr_q <= addr_d;
`ifdef MEM_CLEAR_PATTERN_EN
              data_q <= pattern(addr_d);
`endif
              if (GAP != 0) begin
                state_q <= S_WAIT;
                req_q   <= 1'b0;
                gap_q   <= GAP_LOAD;
              end
            end
          end
        end
        S_WAIT: begin
          if (!pause) begin
            if (gap_q == 8'd0) begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end else begin
              gap_q <= gap_q - 8'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr.wr_req  = req_q;
  assign wr.wr_addr = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_cnt   = pass_q;

endmodule
